// File: rtl/decode_execute_unit_pkg.sv
// Shared instruction-field enums and datapath width for the decode/execute slice.
package decode_execute_unit_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IT_R = 2'b00,
        IT_M = 2'b01,
        IT_B = 2'b10,
        IT_S = 2'b11
    } itype_t;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_SLT  = 3'b101,
        OP_SLTE = 3'b110,
        OP_SEQ  = 3'b111
    } alu_op_t;

    typedef enum logic [2:0] {
        M_SB  = 3'b000,
        M_LB  = 3'b001,
        M_LL  = 3'b010,
        M_LL2 = 3'b011,
        M_LIL = 3'b100,
        M_LIU = 3'b101,
        M_LLR = 3'b110,
        M_NOP = 3'b111
    } m_op_t;

    typedef enum logic [1:0] {
        B_BEQ  = 2'b00,
        B_BLT  = 2'b01,
        B_BLTE = 2'b10,
        B_BUN  = 2'b11
    } b_op_t;

    typedef enum logic [1:0] {
        S_LSL = 2'b00,
        S_LSR = 2'b01,
        S_LSI = 2'b10,
        S_RSI = 2'b11
    } s_op_t;

    // ALU function select; the low eight codes line up with alu_op_t.
    typedef enum logic [3:0] {
        FN_AND  = 4'd0,
        FN_OR   = 4'd1,
        FN_XOR  = 4'd2,
        FN_ADD  = 4'd3,
        FN_SUB  = 4'd4,
        FN_SLT  = 4'd5,
        FN_SLTE = 4'd6,
        FN_SEQ  = 4'd7,
        FN_SHL  = 4'd8,
        FN_SHR  = 4'd9,
        FN_ZERO = 4'd10
    } alu_fn_t;

endpackage

// File: rtl/decode_execute_unit_alu_core.sv
// alu_core: logic/arith/compare/shift on two operands; purely combinational.
module alu_core #(
    parameter int DATA_W = decode_execute_unit_pkg::DATA_W
) (
    input  logic [3:0]        fn,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              equal,
    output logic              less_than
);
    import decode_execute_unit_pkg::*;

    always_comb begin
        equal     = (a == b);
        less_than = (a < b);
        result    = '0;
        case (alu_fn_t'(fn))
            FN_AND:  result = a & b;
            FN_OR:   result = a | b;
            FN_XOR:  result = a ^ b;
            FN_ADD:  result = a + b;
            FN_SUB:  result = a - b;
            FN_SLT:  result = DATA_W'(less_than);
            FN_SLTE: result = DATA_W'(less_than | equal);
            FN_SEQ:  result = DATA_W'(equal);
            // Logical shifts by an amount >= DATA_W already give zero.
            FN_SHL:  result = a << b;
            FN_SHR:  result = a >> b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/decode_execute_unit.sv
// Decode of 9-bit instructions, operand mux and registered compare flags around alu_core.
module decode_execute_unit #(
    parameter int DATA_W = decode_execute_unit_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        mach_code,
    input  logic [DATA_W-1:0] rdat_a,
    input  logic [DATA_W-1:0] rdat_b,
    input  logic [DATA_W-1:0] lut_cur,
    output logic [1:0]        r_addr1,
    output logic [1:0]        r_addr2,
    output logic              reg_to_reg,
    output logic              mem_to_reg,
    output logic              reg_to_mem,
    output logic              lut_to_reg,
    output logic              lut_write,
    output logic              imm_lut_enable,
    output logic [1:0]        lut_reg_to_reg_index,
    output logic [DATA_W-1:0] lut_index,
    output logic [DATA_W-1:0] imm_to_lut_reg,
    output logic              branch_enable,
    output logic [DATA_W-1:0] branch_lut_index,
    output logic [DATA_W-1:0] result,
    output logic              equal,
    output logic              less_than,
    output logic              eq_flag,
    output logic              lt_flag
);
    import decode_execute_unit_pkg::*;

    itype_t            ity;
    alu_op_t           rop;
    m_op_t             mop;
    b_op_t             bop;
    s_op_t             sop;
    alu_fn_t           fn;
    logic              use_imm;
    logic              cmp_op;
    logic [DATA_W-1:0] op_b;

    assign ity = itype_t'(mach_code[8:7]);
    assign rop = alu_op_t'(mach_code[6:4]);
    assign mop = m_op_t'(mach_code[6:4]);
    assign bop = b_op_t'(mach_code[6:5]);
    assign sop = s_op_t'(mach_code[6:5]);

    always_comb begin
        r_addr1              = '0;
        r_addr2              = '0;
        reg_to_reg           = 1'b0;
        mem_to_reg           = 1'b0;
        reg_to_mem           = 1'b0;
        lut_to_reg           = 1'b0;
        lut_write            = 1'b0;
        imm_lut_enable       = 1'b0;
        lut_reg_to_reg_index = '0;
        lut_index            = '0;
        imm_to_lut_reg       = '0;
        branch_enable        = 1'b0;
        branch_lut_index     = '0;
        fn                   = FN_ZERO;
        use_imm              = 1'b0;
        cmp_op               = 1'b0;
        case (ity)
            IT_R: begin
                r_addr1    = mach_code[3:2];
                r_addr2    = mach_code[1:0];
                fn         = alu_fn_t'({1'b0, mach_code[6:4]});
                reg_to_reg = (rop <= OP_SUB);
                cmp_op     = (rop >= OP_SLT);
            end
            IT_M: begin
                case (mop)
                    M_SB: begin
                        r_addr1    = mach_code[3:2];
                        r_addr2    = mach_code[1:0];
                        reg_to_mem = 1'b1;
                    end
                    M_LB: begin
                        r_addr1    = mach_code[3:2];
                        r_addr2    = mach_code[1:0];
                        mem_to_reg = 1'b1;
                    end
                    M_LL: begin
                        lut_index = {{(DATA_W-4){1'b0}}, mach_code[3:0]};
                        lut_write = 1'b1;
                    end
                    M_LL2: begin
                        lut_index = {{(DATA_W-5){1'b0}}, 1'b1, mach_code[3:0]};
                        lut_write = 1'b1;
                    end
                    M_LIL: begin
                        imm_to_lut_reg = {lut_cur[DATA_W-1:4], mach_code[3:0]};
                        imm_lut_enable = 1'b1;
                        lut_write      = 1'b1;
                    end
                    M_LIU: begin
                        imm_to_lut_reg = {mach_code[3:0], lut_cur[DATA_W-5:0]};
                        imm_lut_enable = 1'b1;
                        lut_write      = 1'b1;
                    end
                    M_LLR: begin
                        lut_to_reg           = 1'b1;
                        lut_reg_to_reg_index = mach_code[3:2];
                    end
                    M_NOP: ;
                endcase
            end
            IT_B: begin
                branch_lut_index = {{(DATA_W-5){1'b0}}, mach_code[4:0]};
                case (bop)
                    B_BEQ:  branch_enable = eq_flag;
                    B_BLT:  branch_enable = lt_flag;
                    B_BLTE: branch_enable = eq_flag | lt_flag;
                    B_BUN:  branch_enable = 1'b1;
                endcase
            end
            IT_S: begin
                r_addr1    = mach_code[4:3];
                reg_to_reg = 1'b1;
                case (sop)
                    S_LSL: begin r_addr2 = mach_code[2:1]; fn = FN_SHL; end
                    S_LSR: begin r_addr2 = mach_code[2:1]; fn = FN_SHR; end
                    S_LSI: begin use_imm = 1'b1;           fn = FN_SHL; end
                    S_RSI: begin use_imm = 1'b1;           fn = FN_SHR; end
                endcase
            end
        endcase
    end

    assign op_b = use_imm ? {{(DATA_W-3){1'b0}}, mach_code[2:0]} : rdat_b;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .fn        (fn),
        .a         (rdat_a),
        .b         (op_b),
        .result    (result),
        .equal     (equal),
        .less_than (less_than)
    );

    // Branches only ever see the flags captured by an earlier compare instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            eq_flag <= 1'b0;
            lt_flag <= 1'b0;
        end else if (cmp_op) begin
            eq_flag <= equal;
            lt_flag <= less_than;
        end
    end

endmodule

// File: tb/tb_decode_execute_unit.sv
// Directed vector table, hand sequences and random stimulus against a behavioural model.
module tb_decode_execute_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] mach_code;
    logic [7:0] rdat_a, rdat_b, lut_cur;
    logic [1:0] r_addr1, r_addr2, lut_reg_to_reg_index;
    logic       reg_to_reg, mem_to_reg, reg_to_mem, lut_to_reg, lut_write, imm_lut_enable;
    logic [7:0] lut_index, imm_to_lut_reg, branch_lut_index, result;
    logic       branch_enable, equal, less_than, eq_flag, lt_flag;

    typedef struct packed {
        logic [1:0] r_addr1;
        logic [1:0] r_addr2;
        logic       reg_to_reg;
        logic       mem_to_reg;
        logic       reg_to_mem;
        logic       lut_to_reg;
        logic       lut_write;
        logic       imm_lut_enable;
        logic [1:0] lut_reg_to_reg_index;
        logic [7:0] lut_index;
        logic [7:0] imm_to_lut_reg;
        logic       branch_enable;
        logic [7:0] branch_lut_index;
        logic [7:0] result;
        logic       equal;
        logic       less_than;
    } outs_t;

    typedef struct {
        string      name;
        logic [8:0] mc;
        logic [7:0] a, b, lut;
        int         sel;      // 0 result/reg_to_reg, 1 lut_index/lut_write, 2 imm/lut_write, 3 branch idx/enable
        logic [7:0] exp_val;
        logic       exp_en;
    } vec_t;

    outs_t dut_o;
    int    errors = 0;
    int    checks = 0;
    logic  eq_m = 1'b0, lt_m = 1'b0;

    decode_execute_unit #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset), .mach_code(mach_code),
        .rdat_a(rdat_a), .rdat_b(rdat_b), .lut_cur(lut_cur),
        .r_addr1(r_addr1), .r_addr2(r_addr2),
        .reg_to_reg(reg_to_reg), .mem_to_reg(mem_to_reg), .reg_to_mem(reg_to_mem),
        .lut_to_reg(lut_to_reg), .lut_write(lut_write), .imm_lut_enable(imm_lut_enable),
        .lut_reg_to_reg_index(lut_reg_to_reg_index), .lut_index(lut_index),
        .imm_to_lut_reg(imm_to_lut_reg), .branch_enable(branch_enable),
        .branch_lut_index(branch_lut_index), .result(result),
        .equal(equal), .less_than(less_than), .eq_flag(eq_flag), .lt_flag(lt_flag)
    );

    always #5 clk = ~clk;

    assign dut_o = {r_addr1, r_addr2, reg_to_reg, mem_to_reg, reg_to_mem, lut_to_reg,
                    lut_write, imm_lut_enable, lut_reg_to_reg_index, lut_index,
                    imm_to_lut_reg, branch_enable, branch_lut_index, result, equal, less_than};

    function automatic logic is_cmp(input logic [8:0] mc);
        return (mc[8:7] == 2'b00) && (mc[6:4] >= 3'd5);
    endfunction

    // Reference model built straight from the instruction-set rules.
    function automatic outs_t model(input logic [8:0] mc, input logic [7:0] a, b, lut,
                                    input logic eqf, ltf);
        outs_t o;
        int ia, ib, amt, res, op;
        o = '0; ia = int'(a); ib = int'(b); res = 0;
        case (mc[8:7])
            2'b00: begin
                op = int'(mc[6:4]);
                o.r_addr1 = mc[3:2]; o.r_addr2 = mc[1:0];
                case (op)
                    0: res = ia & ib;
                    1: res = ia | ib;
                    2: res = ia ^ ib;
                    3: res = (ia + ib) % 256;
                    4: res = (ia - ib + 256) % 256;
                    5: res = (ia < ib)  ? 1 : 0;
                    6: res = (ia <= ib) ? 1 : 0;
                    default: res = (ia == ib) ? 1 : 0;
                endcase
                o.reg_to_reg = (op <= 4);
            end
            2'b01: begin
                op = int'(mc[6:4]);
                case (op)
                    0: begin o.r_addr1 = mc[3:2]; o.r_addr2 = mc[1:0]; o.reg_to_mem = 1'b1; end
                    1: begin o.r_addr1 = mc[3:2]; o.r_addr2 = mc[1:0]; o.mem_to_reg = 1'b1; end
                    2: begin o.lut_index = 8'(int'(mc[3:0])); o.lut_write = 1'b1; end
                    3: begin o.lut_index = 8'(16 + int'(mc[3:0])); o.lut_write = 1'b1; end
                    4: begin o.imm_to_lut_reg = 8'((int'(lut) / 16) * 16 + int'(mc[3:0]));
                             o.imm_lut_enable = 1'b1; o.lut_write = 1'b1; end
                    5: begin o.imm_to_lut_reg = 8'(int'(mc[3:0]) * 16 + int'(lut) % 16);
                             o.imm_lut_enable = 1'b1; o.lut_write = 1'b1; end
                    6: begin o.lut_to_reg = 1'b1; o.lut_reg_to_reg_index = mc[3:2]; end
                    default: ;
                endcase
            end
            2'b10: begin
                o.branch_lut_index = 8'(int'(mc[4:0]));
                case (mc[6:5])
                    2'b00: o.branch_enable = eqf;
                    2'b01: o.branch_enable = ltf;
                    2'b10: o.branch_enable = eqf | ltf;
                    default: o.branch_enable = 1'b1;
                endcase
            end
            default: begin
                o.r_addr1 = mc[4:3]; o.reg_to_reg = 1'b1;
                if (mc[6] == 1'b0) begin o.r_addr2 = mc[2:1]; amt = ib; end
                else begin amt = int'(mc[2:0]); ib = amt; end
                if (amt >= 8)          res = 0;
                else if (mc[5] == 1'b0) res = (ia * (1 << amt)) % 256;
                else                   res = ia / (1 << amt);
            end
        endcase
        o.result = 8'(res);
        o.equal = (ia == ib);
        o.less_than = (ia < ib);
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one instruction for a cycle: check combinational outputs, then the flags after the edge.
    task automatic step(input logic [8:0] m, input logic [7:0] a, b, l,
                        input logic r, input string nm);
        outs_t exp;
        @(negedge clk);
        mach_code = m; rdat_a = a; rdat_b = b; lut_cur = l; reset = r;
        #1;
        exp = model(m, a, b, l, eq_m, lt_m);
        chk({nm, "/comb"}, 64'(dut_o), 64'(exp));
        @(posedge clk);
        if (!r) begin
            eq_m = 1'b0; lt_m = 1'b0;
        end else if (is_cmp(m)) begin
            eq_m = (a == b); lt_m = (a < b);
        end
        #1;
        chk({nm, "/flags"}, {62'd0, eq_flag, lt_flag}, {62'd0, eq_m, lt_m});
    endtask

    initial begin
        vec_t vt[$];
        mach_code = '0; rdat_a = '0; rdat_b = '0; lut_cur = '0; reset = 1'b0;

        vt.push_back('{"and",  9'h001, 8'hF0, 8'h3C, 8'h00, 0, 8'h30, 1'b1});
        vt.push_back('{"or",   9'h011, 8'hF0, 8'h3C, 8'h00, 0, 8'hFC, 1'b1});
        vt.push_back('{"xor",  9'h021, 8'hF0, 8'h3C, 8'h00, 0, 8'hCC, 1'b1});
        vt.push_back('{"add",  9'h031, 8'hF0, 8'h3C, 8'h00, 0, 8'h2C, 1'b1});
        vt.push_back('{"sub",  9'h041, 8'hF0, 8'h3C, 8'h00, 0, 8'hB4, 1'b1});
        vt.push_back('{"lsi",  9'h1CB, 8'h81, 8'h00, 8'h00, 0, 8'h08, 1'b1});
        vt.push_back('{"lsr9", 9'h1AC, 8'h81, 8'h09, 8'h00, 0, 8'h00, 1'b1});
        vt.push_back('{"liu",  9'h0DA, 8'h00, 8'h00, 8'h05, 2, 8'hA5, 1'b1});
        vt.push_back('{"lil",  9'h0C6, 8'h00, 8'h00, 8'hC3, 2, 8'hC6, 1'b1});
        vt.push_back('{"ll2",  9'h0B3, 8'h00, 8'h00, 8'h00, 1, 8'h13, 1'b1});
        vt.push_back('{"bun",  9'h17F, 8'h00, 8'h00, 8'h00, 3, 8'h1F, 1'b1});
        vt.push_back('{"slte", 9'h061, 8'h07, 8'h07, 8'h00, 0, 8'h01, 1'b0});
        vt.push_back('{"mnop", 9'h0F0, 8'h12, 8'h34, 8'h56, 0, 8'h00, 1'b0});

        // Reset state
        step(9'h000, 8'h00, 8'h00, 8'h00, 1'b0, "rst");
        chk("rst_eq", {63'd0, eq_flag}, 64'd0);
        chk("rst_lt", {63'd0, lt_flag}, 64'd0);

        foreach (vt[i]) begin
            step(vt[i].mc, vt[i].a, vt[i].b, vt[i].lut, 1'b1, vt[i].name);
            case (vt[i].sel)
                0: begin chk({vt[i].name, "/val"}, 64'(result), 64'(vt[i].exp_val));
                         chk({vt[i].name, "/en"}, 64'(reg_to_reg), 64'(vt[i].exp_en)); end
                1: begin chk({vt[i].name, "/val"}, 64'(lut_index), 64'(vt[i].exp_val));
                         chk({vt[i].name, "/en"}, 64'(lut_write), 64'(vt[i].exp_en)); end
                2: begin chk({vt[i].name, "/val"}, 64'(imm_to_lut_reg), 64'(vt[i].exp_val));
                         chk({vt[i].name, "/en"}, 64'(lut_write), 64'(vt[i].exp_en)); end
                default: begin chk({vt[i].name, "/val"}, 64'(branch_lut_index), 64'(vt[i].exp_val));
                         chk({vt[i].name, "/en"}, 64'(branch_enable), 64'(vt[i].exp_en)); end
            endcase
        end

        // SLT 5<9 sets lt_flag; BLT then taken, BEQ not
        step(9'h051, 8'd5, 8'd9, 8'h00, 1'b1, "slt");
        chk("slt_lt", {63'd0, lt_flag}, 64'd1);
        chk("slt_eq", {63'd0, eq_flag}, 64'd0);
        step(9'h120, 8'h00, 8'h00, 8'h00, 1'b1, "blt");
        chk("blt_take", 64'(branch_enable), 64'd1);
        step(9'h100, 8'h00, 8'h00, 8'h00, 1'b1, "beq");
        chk("beq_nottake", 64'(branch_enable), 64'd0);
        step(9'h17F, 8'h00, 8'h00, 8'h00, 1'b1, "bun_flags");
        chk("bun_en", 64'(branch_enable), 64'd1);

        // Reset wins over a simultaneous SEQ, then SEQ lands once reset is released
        step(9'h071, 8'd7, 8'd7, 8'h00, 1'b0, "seq_rst");
        chk("seq_rst_eq", {63'd0, eq_flag}, 64'd0);
        step(9'h071, 8'd7, 8'd7, 8'h00, 1'b1, "seq");
        chk("seq_eq", {63'd0, eq_flag}, 64'd1);
        chk("seq_lt", {63'd0, lt_flag}, 64'd0);

        for (int n = 0; n < 400; n++) begin
            step(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)),
                 ((n % 4) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 15) != 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_execute_unit.md
DECODE_EXECUTE_UNIT -- requirements
Module: decode_execute_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named as below.
REQ-002 Parameter: DATA_W, 8, datapath width; all listed 8-bit ports SHALL equal DATA_W.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-low reset.
REQ-005 mach_code  in  9  current instruction.
REQ-006 rdat_a / rdat_b  in  8 each  register-file read data for r_addr1 / r_addr2.
REQ-007 lut_cur  in  8  current LUT special-register value.
REQ-008 r_addr1, r_addr2  out  2 each  register read addresses.
REQ-009 Writeback selects, 1 bit each, out: reg_to_reg, mem_to_reg, reg_to_mem, lut_to_reg, lut_write, imm_lut_enable.
REQ-010 lut_reg_to_reg_index  out  2  LLR destination register.
REQ-011 lut_index  out  8  LUT index.
REQ-012 imm_to_lut_reg  out  8  LIL/LIU merge value.
REQ-013 branch_enable  out  1  PC jump request.
REQ-014 branch_lut_index  out  8  branch LUT index.
REQ-015 result  out  8  ALU result.
REQ-016 equal, less_than  out  1 each  combinational compare of ALU operands.
REQ-017 eq_flag, lt_flag  out  1 each  registered compare flags.

Function
REQ-018 Decode SHALL be combinational on mach_code; type = [8:7]; any output not driven by the decoded instruction SHALL be 0.
REQ-019 R-type (00): op=[6:4], r_addr1=[3:2] (dest/op A), r_addr2=[1:0]; ops 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (mod 256), 101 SLT, 110 SLTE, 111 SEQ.
REQ-020 AND..SUB SHALL assert reg_to_reg; SLT/SLTE/SEQ SHALL NOT write back; result = 1 if condition true, else 0.
REQ-021 All compares SHALL be unsigned: equal=(A==B), less_than=(A<B), for every instruction.
REQ-022 On any SLT/SLTE/SEQ, eq_flag<=equal and lt_flag<=less_than at the next clk edge; otherwise hold.
REQ-023 M-type (01), op=[6:4]: 000 SB r_addr1=[3:2] addr reg, r_addr2=[1:0] value reg, reg_to_mem=1; 001 LB r_addr1=[3:2] dest, r_addr2=[1:0] addr reg, mem_to_reg=1.
REQ-024 M 010 LL: lut_index={0000,[3:0]}, lut_write=1; 011 LL2: lut_index={0001,[3:0]}, lut_write=1.
REQ-025 M 100 LIL: imm_to_lut_reg={lut_cur[7:4],[3:0]}; 101 LIU: {[3:0],lut_cur[3:0]}; both imm_lut_enable=1, lut_write=1.
REQ-026 M 110 LLR: lut_to_reg=1, lut_reg_to_reg_index=[3:2]; M 111 SHALL be a no-op.
REQ-027 B-type (10): op=[6:5], branch_lut_index={000,[4:0]}; branch_enable = BEQ(00) eq_flag, BLT(01) lt_flag, BLTE(10) eq_flag|lt_flag, BUN(11) 1; flags used are registered values.
REQ-028 S-type (11): op=[6:5], r_addr1=[4:3], reg_to_reg=1; LSL(00)/LSR(01) r_addr2=[2:1], amount=rdat_b; LSI(10)/RSI(11) amount={00000,[2:0]}.
REQ-029 Operand mux: op A=rdat_a; op B=zero-extended immediate for LSI/RSI, else rdat_b.
REQ-030 Shifts SHALL be logical, zero fill; amount >= 8 yields 0.
REQ-031 mach_code 9'h000 SHALL decode as AND R0,R0 (no special-casing; halt is external).

Reset
REQ-032 reset low at a clk edge SHALL clear eq_flag and lt_flag to 0; reset SHALL override a simultaneous compare.
REQ-033 Combinational outputs SHALL not depend on reset.

Structure
REQ-034 A shared package SHALL hold the instruction-type, ALU-op, M-op, B-op and S-op enums and DATA_W.
REQ-035 The ALU (arithmetic, compare, shift) SHALL be one sub-module, alu_core; decode, operand mux and flag register live in the top.

Verification
REQ-036 A=8'hF0,B=8'h3C: AND->8'h30, OR->8'hFC, XOR->8'hCC, ADD->8'h2C, SUB->8'hB4, reg_to_reg=1.
REQ-037 SLT A=5,B=9 -> result 1, lt_flag=1/eq_flag=0 next cycle; then BLT -> branch_enable=1, BEQ -> 0.
REQ-038 LSI r1 by 3 with rdat_a=8'h81 -> 8'h08; LSR by rdat_b=9 -> 8'h00.
REQ-039 LIU 4'hA with lut_cur=8'h05 -> imm_to_lut_reg=8'hA5, lut_write=1; LL2 4'h3 -> lut_index=8'h13.
REQ-040 SEQ A=B=7 with reset low same edge -> flags 0; next edge, reset high -> eq_flag=1.
REQ-041 BUN imm 5'h1F -> branch_enable=1, branch_lut_index=8'h1F regardless of flags.
